bcd_entry_register: RTL and testbench

Parametrised keypad digit-entry register for the keyboard path, the successor to the fixed 3-digit BCD shift register. It accumulates up to NUM_DIGITS BCD digits from the scan-code decoder and adds backspace, a sign flag, overflow detection and leading-zero suppression. A multi-cycle BCD-to-binary converter with a busy/done handshake feeds the arithmetic unit.

---
 rtl/bcd_entry_register_if.sv | 43 ++++
 rtl/bcd_entry_register.sv | 143 ++++++++++++++
 tb/tb_bcd_entry_register.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_entry_register_if.sv
// Keypad digit-entry bus: entry strobes from the scan-code decoder towards the
// register, and the entry / conversion results back towards the arithmetic unit.
//
// Handshake: every input is a one-cycle strobe that is sampled on the rising
// edge. There is no back-pressure; a strobe the register cannot act on is dropped.
// The register raises busy for the whole conversion. It then pulses done for
// exactly one cycle, and bin_value is valid from that cycle onward.
interface bcd_entry_register_if #(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_WIDTH  = 10
);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic [3:0]              digit_val;
    logic                    digit_valid;
    logic                    backspace;
    logic                    clear;
    logic                    neg_toggle;
    logic                    convert;

    logic [4*NUM_DIGITS-1:0] bcd_value;
    logic [CNT_W-1:0]        digit_count;
    logic                    negative;
    logic                    overflow;
    logic                    busy;
    logic                    done;
    logic [BIN_WIDTH-1:0]    bin_value;
    logic [1:0]              state_dbg;

    // Keyboard decoder / test driver side
    modport master (
        output digit_val, digit_valid, backspace, clear, neg_toggle, convert,
        input  bcd_value, digit_count, negative, overflow, busy, done, bin_value,
               state_dbg
    );

    // Entry register side
    modport slave (
        input  digit_val, digit_valid, backspace, clear, neg_toggle, convert,
        output bcd_value, digit_count, negative, overflow, busy, done, bin_value,
               state_dbg
    );
endinterface

// File: rtl/bcd_entry_register.sv
// Keypad BCD digit-entry register with backspace, sign, sticky overflow,
// leading-zero suppression and a serial BCD-to-binary converter.
// The converter takes one digit per cycle, most significant digit first.
module bcd_entry_register #(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_WIDTH  = 10
) (
    input  logic               clk,
    input  logic               rst,
    bcd_entry_register_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [BCD_W-1:0]     bcd_q, snap_q, bcd_shl, bcd_shr;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q, ovf_q, busy_q, done_q;
    logic [BIN_WIDTH-1:0] acc_q, bin_q, acc_next;
    logic [IDX_W-1:0]     idx_q;
    logic [3:0]           cur_digit;
    logic                 entry_en, digit_ok, last_step, lead_zero;

    // Shift-in / shift-out views of the entry register; a single digit has no upper part
    generate
        if (NUM_DIGITS > 1) begin : g_multi
            assign bcd_shl = {bcd_q[BCD_W-5:0], bus.digit_val};
            assign bcd_shr = {4'd0, bcd_q[BCD_W-1:4]};
        end else begin : g_single
            assign bcd_shl = bus.digit_val;
            assign bcd_shr = '0;
        end
    endgenerate

    // The entry strobes are honoured outside CONV; only clear reaches into a conversion
    assign entry_en  = (state != S_CONV);
    assign digit_ok  = bus.digit_valid && (bus.digit_val <= 4'd9);
    assign lead_zero = (cnt_q == '0) && (bus.digit_val == 4'd0);
    assign cur_digit = snap_q[{idx_q, 2'b00} +: 4];
    assign last_step = (idx_q == '0);
    // acc*10 as two shifts; the width constraint on BIN_WIDTH rules out wrap
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + {{(BIN_WIDTH-4){1'b0}}, cur_digit};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // FSM next state: clear both blocks a start and aborts a running conversion
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.convert && !bus.clear) state_next = S_CONV;
            S_CONV:  if (bus.clear)                 state_next = S_IDLE;
                     else if (last_step)            state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Entry register: clear > backspace > digit, sign toggle alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (bus.clear) begin
            bcd_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (entry_en) begin
            if (bus.neg_toggle) neg_q <= ~neg_q;
            if (bus.backspace) begin
                if (cnt_q != '0) begin
                    bcd_q <= bcd_shr;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end else if (digit_ok) begin
                if (cnt_q == FULL_CNT) begin
                    ovf_q <= 1'b1;
                end else if (!lead_zero) begin
                    bcd_q <= bcd_shl;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Converter datapath on a frozen snapshot, plus registered busy/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            bin_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_next == S_CONV);
            done_q <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (state_next == S_CONV) begin
                        snap_q <= bcd_q;
                        acc_q  <= '0;
                        idx_q  <= LAST_IDX;
                    end
                end
                S_CONV: begin
                    if (bus.clear) begin
                        bin_q <= '0;
                    end else begin
                        acc_q <= acc_next;
                        idx_q <= idx_q - IDX_W'(1);
                        if (last_step) bin_q <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd_value   = bcd_q;
    assign bus.digit_count = cnt_q;
    assign bus.negative    = neg_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.bin_value   = bin_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_bcd_entry_register.sv
// Bench for bcd_entry_register: directed scenarios followed by random strobes.
// The reference model holds the entered digits as a list of integers.
module tb_bcd_entry_register;
  localparam int N     = 3;
  localparam int BW    = 10;
  localparam int CNT_W = $clog2(N + 1);
  localparam int BCD_W = 4 * N;
  localparam int REC_W = 32 + BCD_W + CNT_W + 3 + BW;
  localparam int CNV_W = 32 + BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_entry_register_if #(.NUM_DIGITS(N), .BIN_WIDTH(BW)) bus ();
  bcd_entry_register #(.NUM_DIGITS(N), .BIN_WIDTH(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model state ----------------
  int digs[$];
  bit m_neg, m_ovf;
  int m_bin, pend_bin;
  int bs0 = -10;
  int be0 = -10;
  bit aborted = 1'b1;

  logic [REC_W-1:0] exp_q[$];
  logic [CNV_W-1:0] cnv_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit in_reset = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BCD_W-1:0] model_bcd();
    logic [BCD_W-1:0] r = '0;
    foreach (digs[i]) r = (r << 4) | BCD_W'(digs[i]);
    return r;
  endfunction

  function automatic int model_val();
    int v = 0;
    int p = 1;
    for (int i = digs.size() - 1; i >= 0; i--) begin
      v += digs[i] * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic void model_clear();
    digs.delete();
    m_neg = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of strobes, advances the model and queues the expectation.
  task automatic step(input bit dv, input int dval, input bit bs, input bit clr,
                      input bit ng, input bit cv);
    int c;
    bit in_conv, in_done, busy_exp;
    @(posedge clk);
    #1;
    c = cyc;
    bus.digit_valid = dv;
    bus.digit_val   = 4'(dval);
    bus.backspace   = bs;
    bus.clear       = clr;
    bus.neg_toggle  = ng;
    bus.convert     = cv;
    in_conv = (c >= bs0) && (c <= be0);
    in_done = !aborted && (c == be0 + 1);
    if (in_conv) begin
      if (clr) begin
        model_clear();
        m_bin   = 0;
        aborted = 1'b1;
        be0     = c;
        if (cnv_q.size() > 0) void'(cnv_q.pop_back());
      end
    end else begin
      if (cv && !clr && !in_done) begin
        pend_bin = model_val();
        bs0      = c + 1;
        be0      = c + N;
        aborted  = 1'b0;
        cnv_q.push_back({32'(c + N + 1), BW'(pend_bin)});
      end
      if (clr) begin
        model_clear();
      end else begin
        if (ng) m_neg = !m_neg;
        if (bs) begin
          if (digs.size() > 0) void'(digs.pop_back());
        end else if (dv && dval <= 9) begin
          if (digs.size() == N) m_ovf = 1'b1;
          else if (!(digs.size() == 0 && dval == 0)) digs.push_back(dval);
        end
      end
    end
    if (!aborted && (c + 1 == be0 + 1)) m_bin = pend_bin;
    busy_exp = (c + 1 >= bs0) && (c + 1 <= be0);
    exp_q.push_back({32'(c + 1), model_bcd(), CNT_W'(digs.size()), m_neg, m_ovf,
                     busy_exp, BW'(m_bin)});
  endtask

  task automatic idle();             step(0, 0, 0, 0, 0, 0); endtask
  task automatic dig(input int v);   step(1, v, 0, 0, 0, 0); endtask
  task automatic bksp();             step(0, 0, 1, 0, 0, 0); endtask
  task automatic clr();              step(0, 0, 0, 1, 0, 0); endtask
  task automatic neg();              step(0, 0, 0, 0, 1, 0); endtask
  task automatic conv();             step(0, 0, 0, 0, 0, 1); endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_reset = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    cnv_q.delete();
    bus.digit_valid = 0; bus.digit_val = 0; bus.backspace = 0;
    bus.clear = 0; bus.neg_toggle = 0; bus.convert = 0;
    #1;
    check("rst_bcd_value", bus.bcd_value, 0);
    check("rst_digit_count", bus.digit_count, 0);
    check("rst_negative", bus.negative, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_bin_value", bus.bin_value, 0);
    model_clear();
    m_bin = 0; pend_bin = 0; bs0 = -10; be0 = -10; aborted = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [REC_W-1:0] r;
  logic [CNV_W-1:0] q;
  always @(negedge clk) begin
    if (!in_reset) begin
      if (exp_q.size() > 0) begin
        r = exp_q[0];
        if (int'(r[REC_W-1 -: 32]) <= cyc) begin
          void'(exp_q.pop_front());
          check("bcd_value", bus.bcd_value, r[BW+3+CNT_W +: BCD_W]);
          check("digit_count", bus.digit_count, r[BW+3 +: CNT_W]);
          check("negative", bus.negative, r[BW+2]);
          check("overflow", bus.overflow, r[BW+1]);
          check("busy", bus.busy, r[BW]);
          check("bin_value", bus.bin_value, r[BW-1:0]);
        end
      end
      if (bus.done === 1'b1) begin
        if (cnv_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          q = cnv_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(q[CNV_W-1 -: 32]));
          check("bin_on_done", bus.bin_value, q[BW-1:0]);
        end
      end else if (cnv_q.size() > 0) begin
        q = cnv_q[0];
        if (int'(q[CNV_W-1 -: 32]) < cyc) begin
          void'(cnv_q.pop_front());
          n_cmp++;
          n_bad++;
          $display("FAIL done_missing: got no done expected done at cycle %0d with %0d",
                   q[CNV_W-1 -: 32], q[BW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.digit_valid = 0; bus.digit_val = 0; bus.backspace = 0;
    bus.clear = 0; bus.neg_toggle = 0; bus.convert = 0;
    do_reset();

    // Entry and conversion of 427
    dig(4); dig(2); dig(7); idle();
    check("p1_bcd", bus.bcd_value, 12'h427);
    check("p1_count", bus.digit_count, 3);
    conv();
    repeat (N + 1) idle();
    check("p1_bin", bus.bin_value, 427);

    // Overflow, backspace keeps overflow, clear
    clr(); dig(1); dig(2); dig(3); dig(9); idle();
    check("p2_bcd", bus.bcd_value, 12'h123);
    check("p2_ovf", bus.overflow, 1);
    bksp(); idle();
    check("p2_bs_bcd", bus.bcd_value, 12'h012);
    check("p2_bs_ovf", bus.overflow, 1);
    clr(); idle();

    // Leading zeros, invalid digit, double sign toggle
    dig(0); dig(0); dig(5); step(1, 11, 0, 0, 0, 0); neg(); idle();
    check("p3_neg_set", bus.negative, 1);
    neg(); idle();
    check("p3_bcd", bus.bcd_value, 12'h005);
    check("p3_count", bus.digit_count, 1);

    // Strobes dropped while converting
    clr(); dig(3); dig(4); dig(1); conv(); idle();
    step(1, 8, 0, 0, 0, 1);
    repeat (N + 3) idle();
    check("p4_bin", bus.bin_value, 341);
    check("p4_bcd", bus.bcd_value, 12'h341);

    // Clear aborts a conversion
    clr(); dig(9); dig(9); dig(9); conv(); idle(); clr(); idle();
    check("p5_busy", bus.busy, 0);
    check("p5_bin", bus.bin_value, 0);
    repeat (N + 2) idle();

    // Asynchronous reset in the middle of a conversion
    dig(5); dig(6); conv(); idle();
    do_reset();

    // Backspace wins over a simultaneous digit
    dig(1); dig(2); step(1, 7, 1, 0, 0, 0); idle();
    check("bs_priority", bus.bcd_value, 12'h001);

    // Random strobes
    for (int i = 0; i < 1500; i++) begin
      int sel;
      int dval;
      bit ng;
      sel  = $urandom_range(0, 99);
      dval = $urandom_range(0, 11);
      ng   = ($urandom_range(0, 9) == 0);
      if (sel < 3)       step(0, 0, 0, 1, ng, 0);
      else if (sel < 11) step(0, 0, 0, 0, ng, 1);
      else if (sel < 21) step(0, 0, 1, 0, ng, 0);
      else if (sel < 61) step(1, dval, 0, 0, ng, 0);
      else if (sel < 64) step(1, dval, 1, 0, ng, 0);
      else               step(0, 0, 0, 0, ng, 0);
    end

    repeat (N + 4) idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("conv_queue_drained", cnv_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
